// File: rtl/spi_slave_param_if.sv
// spi_slave_param_if -- bus between an SPI master (or test bench) and spi_slave_param.
//   SS_n, MOSI          : serial select / data from the master
//   tx_valid, tx_data   : parallel read data offered to the slave
//   rx_valid, rx_data   : received frame ({cmd[1:0], payload}) and its strobe
//   MISO                : serial data back to the master
//   frame_err           : aborted frame or tx_data timeout strobe
interface spi_slave_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    localparam int PW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int FW = PW + 2;

    logic              SS_n;
    logic              MOSI;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic [FW-1:0]     rx_data;
    logic              MISO;
    logic              frame_err;

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  rx_valid, rx_data, MISO, frame_err
    );

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output rx_valid, rx_data, MISO, frame_err
    );
endinterface

// File: rtl/spi_slave_param.sv
// spi_slave_param -- SPI slave running on the system clock.
// A frame is FW = max(ADDR_W, DATA_W) + 2 bits: two command bits then the payload.
// Command MSB 0 is a write; MSB 1 is a read, taken as the read address the first
// time and as the read-data request once an address has been seen. A read-data
// request waits up to TX_TIMEOUT cycles for tx_valid and then shifts tx_data out
// on MISO.
// Ports:
//   clk  : single clock, everything happens on its rising edge
//   rst  : asynchronous, active-high reset
//   bus  : spi_slave_param_if slave modport (SS_n, MOSI, tx_*, rx_*, MISO, frame_err)
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int LSB_FIRST  = 0,
    parameter int TX_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    spi_slave_param_if.slave  bus
);
    localparam int PW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int FW = PW + 2;
    localparam int CW = $clog2(FW + 1);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;           // frame bit index, then SEND bit index
    logic [7:0]        tcnt;          // cycles spent in WAIT_TX
    logic [FW-1:0]     fr;            // frame being assembled
    logic [FW-1:0]     fr_nxt;
    logic [DATA_W-1:0] sr;            // remaining bits to send
    logic              rd_addr_seen;
    logic              rx_valid_r;
    logic [FW-1:0]     rx_data_r;
    logic              miso_r;
    logic              frame_err_r;
    int                pos;

    assign bus.rx_valid  = rx_valid_r;
    assign bus.rx_data   = rx_data_r;
    assign bus.MISO      = miso_r;
    assign bus.frame_err = frame_err_r;

    // Destination of the bit currently on MOSI. The command field always lands
    // in the top two bits; only the payload order depends on LSB_FIRST.
    // fr is cleared at frame start, so OR-ing the bit in is enough.
    always_comb begin
        if (LSB_FIRST == 0 || int'(cnt) < 2)
            pos = FW - 1 - int'(cnt);
        else
            pos = int'(cnt) - 2;
        fr_nxt = fr | (FW'(bus.MOSI) << pos);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tcnt         <= '0;
            fr           <= '0;
            sr           <= '0;
            rd_addr_seen <= 1'b0;
            rx_valid_r   <= 1'b0;
            rx_data_r    <= '0;
            miso_r       <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            miso_r      <= 1'b0;   // only SEND drives a non-zero MISO

            // Deselect wins over everything else, including a same-cycle
            // tx_valid. Leaving DONE this way is the normal exit, not an error.
            if (state != IDLE && bus.SS_n) begin
                state <= IDLE;
                cnt   <= '0;
                tcnt  <= '0;
                if (state != DONE) frame_err_r <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!bus.SS_n) state <= CHK_CMD;
                    end

                    CHK_CMD: begin
                        fr  <= {bus.MOSI, {(FW-1){1'b0}}};
                        cnt <= CW'(1);
                        if (!bus.MOSI)         state <= WRITE;
                        else if (!rd_addr_seen) state <= READ_ADD;
                        else                    state <= READ_DATA;
                    end

                    WRITE, READ_ADD, READ_DATA: begin
                        fr <= fr_nxt;
                        if (cnt == CW'(FW - 1)) begin
                            rx_data_r  <= fr_nxt;
                            rx_valid_r <= 1'b1;
                            cnt        <= CW'(FW);
                            tcnt       <= '0;
                            if (state == READ_DATA) begin
                                state <= WAIT_TX;
                            end else begin
                                if (state == READ_ADD) rd_addr_seen <= 1'b1;
                                state <= DONE;
                            end
                        end else if (cnt < CW'(FW)) begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    WAIT_TX: begin
                        if (bus.tx_valid) begin
                            // First bit goes out the cycle after capture.
                            if (LSB_FIRST != 0) begin
                                miso_r <= bus.tx_data[0];
                                sr     <= bus.tx_data >> 1;
                            end else begin
                                miso_r <= bus.tx_data[DATA_W-1];
                                sr     <= bus.tx_data << 1;
                            end
                            cnt   <= CW'(1);
                            state <= SEND;
                        end else if (tcnt == 8'(TX_TIMEOUT - 1)) begin
                            frame_err_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end

                    SEND: begin
                        if (cnt == CW'(DATA_W)) begin
                            rd_addr_seen <= 1'b0;
                            state        <= DONE;
                        end else begin
                            if (LSB_FIRST != 0) begin
                                miso_r <= sr[0];
                                sr     <= sr >> 1;
                            end else begin
                                miso_r <= sr[DATA_W-1];
                                sr     <= sr << 1;
                            end
                            cnt <= cnt + 1'b1;
                        end
                    end

                    DONE: ;   // held until SS_n rises

                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param -- self-checking bench for spi_slave_param.
// dut_a: defaults (FW=10, MSB-first). dut_b: DATA_W=12, ADDR_W=10, LSB-first (FW=14).
// Expected rx_data values are queued when a frame is driven and popped by a
// monitor on every rx_valid pulse.
module tb_spi_slave_param;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8),  .ADDR_W(8))  ifa ();
    spi_slave_param_if #(.DATA_W(12), .ADDR_W(10)) ifb ();

    spi_slave_param #(.DATA_W(8), .ADDR_W(8), .LSB_FIRST(0), .TX_TIMEOUT(15))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    spi_slave_param #(.DATA_W(12), .ADDR_W(10), .LSB_FIRST(1), .TX_TIMEOUT(15))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    int checks = 0;
    int errors = 0;
    int erra   = 0;
    int errb   = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    typedef struct {
        logic [15:0] frame;
        logic [15:0] exp_rx;
        bit          send;
        logic [15:0] tx;
        int          delay;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- DUT access helpers (d: 0 = dut_a, 1 = dut_b) ----------
    task automatic set_ss(input int d, input logic v);
        if (d == 0) ifa.SS_n = v; else ifb.SS_n = v;
    endtask

    task automatic set_mosi(input int d, input logic v);
        if (d == 0) ifa.MOSI = v; else ifb.MOSI = v;
    endtask

    task automatic set_tx(input int d, input logic v, input logic [15:0] data);
        if (d == 0) begin ifa.tx_valid = v; ifa.tx_data = data[7:0];  end
        else        begin ifb.tx_valid = v; ifb.tx_data = data[11:0]; end
    endtask

    function automatic logic get_miso(input int d);
        return (d == 0) ? ifa.MISO : ifb.MISO;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? ifa.frame_err : ifb.frame_err;
    endfunction

    function automatic logic [15:0] get_rx(input int d);
        return (d == 0) ? 16'(ifa.rx_data) : 16'(ifb.rx_data);
    endfunction

    function automatic int fw_of(input int d);
        return (d == 0) ? 10 : 14;
    endfunction

    function automatic int dw_of(input int d);
        return (d == 0) ? 8 : 12;
    endfunction

    // Serial bit k of a frame: command bits first, payload MSB- or LSB-first.
    function automatic logic frame_bit(input logic [15:0] f, input int k, input int fw, input bit lsb);
        logic [15:0] t;
        if (!lsb || k < 2) t = f >> (fw - 1 - k);
        else               t = f >> (k - 2);
        return t[0];
    endfunction

    // ---------------- scoreboard monitor ------------------------------------
    always @(negedge clk) begin
        if (ifa.rx_valid) begin
            if (qa.size() == 0) chk("rx_unexpected_a", 32'(ifa.rx_data), 32'hFFFF_FFFF);
            else                chk("rx_data_a", 32'(ifa.rx_data), 32'(qa.pop_front()));
        end
        if (ifb.rx_valid) begin
            if (qb.size() == 0) chk("rx_unexpected_b", 32'(ifb.rx_data), 32'hFFFF_FFFF);
            else                chk("rx_data_b", 32'(ifb.rx_data), 32'(qb.pop_front()));
        end
        if (ifa.frame_err) erra++;
        if (ifb.frame_err) errb++;
    end

    // ---------------- sequences ---------------------------------------------
    // Returns on the first falling edge after the last bit is sampled
    // (the cycle rx_valid is visible).
    task automatic send_frame(input int d, input logic [15:0] f, input logic [15:0] exp_rx);
        bit bad = 0;
        if (d == 0) qa.push_back(exp_rx); else qb.push_back(exp_rx);
        @(negedge clk) set_ss(d, 1'b0);
        for (int k = 0; k < fw_of(d); k++) begin
            @(negedge clk) set_mosi(d, frame_bit(f, k, fw_of(d), d == 1));
            if (get_miso(d)) bad = 1;
        end
        @(negedge clk) set_mosi(d, 1'b0);
        chk("miso_zero_in_frame", 32'(bad), 32'd0);
    endtask

    // Call while the DUT is in WAIT_TX; checks every MISO bit.
    task automatic read_out(input int d, input logic [15:0] tx, input int delay);
        logic [15:0] t;
        repeat (delay) @(negedge clk);
        set_tx(d, 1'b1, tx);
        @(negedge clk) set_tx(d, 1'b0, 16'h0);
        for (int i = 0; i < dw_of(d); i++) begin
            if (i > 0) @(negedge clk);
            t = (d == 1) ? (tx >> i) : (tx >> (dw_of(d) - 1 - i));
            chk("miso_bit", 32'(get_miso(d)), 32'(t[0]));
        end
        @(negedge clk) chk("miso_zero_after_send", 32'(get_miso(d)), 32'd0);
    endtask

    // Select held, tx_valid held high: a DUT sitting in DONE must stay silent.
    task automatic hold_quiet(input int d, input int n);
        bit bad = 0;
        set_tx(d, 1'b1, 16'hFFFF);
        repeat (n) begin
            @(negedge clk);
            if (get_miso(d) || get_err(d)) bad = 1;
        end
        set_tx(d, 1'b0, 16'h0);
        chk("quiet_in_done", 32'(bad), 32'd0);
    endtask

    task automatic end_frame(input int d);
        @(negedge clk) set_ss(d, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int  e0;
        bit  bad;

        vt[0] = '{16'b00_1010_0101, 16'h0A5, 0, 16'h00, 0};   // write
        vt[1] = '{16'b10_0011_0000, 16'h230, 0, 16'h00, 0};   // read address
        vt[2] = '{16'b11_0000_0000, 16'h300, 1, 16'hC3, 3};   // read data
        vt[3] = '{16'b11_1111_1111, 16'h3FF, 0, 16'h00, 0};   // address flag cleared: read address
        vt[4] = '{16'b01_0101_1010, 16'h15A, 0, 16'h00, 0};   // write
        vt[5] = '{16'b11_0101_0101, 16'h355, 1, 16'h5A, 0};   // read data
        vt[6] = '{16'b10_1111_0000, 16'h2F0, 0, 16'h00, 0};   // read address
        vt[7] = '{16'b00_0000_0000, 16'h000, 0, 16'h00, 0};   // write

        rst = 1'b1;
        set_ss(0, 1'b1); set_mosi(0, 1'b0); set_tx(0, 1'b0, 16'h0);
        set_ss(1, 1'b1); set_mosi(1, 1'b0); set_tx(1, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {28'd0, ifa.rx_valid, ifa.MISO, ifa.frame_err, |ifa.rx_data}, 32'd0);
        chk("reset_outputs_b", {28'd0, ifb.rx_valid, ifb.MISO, ifb.frame_err, |ifb.rx_data}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven frames on dut_a
        for (int i = 0; i < 8; i++) begin
            e0 = erra;
            send_frame(0, vt[i].frame, vt[i].exp_rx);
            if (vt[i].send) read_out(0, vt[i].tx, vt[i].delay);
            else            hold_quiet(0, 20);
            chk("rx_data_stable", 32'(get_rx(0)), 32'(vt[i].exp_rx));
            end_frame(0);
            chk("no_frame_err", 32'(erra - e0), 32'd0);
        end

        // Deselect after 5 write bits
        e0 = erra;
        @(negedge clk) set_ss(0, 1'b0);
        for (int k = 0; k < 5; k++) @(negedge clk) set_mosi(0, frame_bit(16'h0A5, k, 10, 0));
        @(negedge clk) set_ss(0, 1'b1);
        @(negedge clk) chk("abort_err_pulse", 32'(get_err(0)), 32'd1);
        @(negedge clk) chk("abort_err_width", 32'(get_err(0)), 32'd0);
        chk("abort_err_count", 32'(erra - e0), 32'd1);

        // Address already seen (last table entry pair): read data, no tx_valid
        e0 = erra;
        send_frame(0, 16'b11_0000_0000, 16'h300);
        bad = 0;
        for (int c = 1; c < 15; c++) begin
            @(negedge clk);
            if (get_err(0) || get_miso(0)) bad = 1;
        end
        chk("timeout_early", 32'(bad), 32'd0);
        @(negedge clk) chk("timeout_err_at_15", 32'(get_err(0)), 32'd1);
        chk("timeout_miso", 32'(get_miso(0)), 32'd0);
        @(negedge clk) chk("timeout_err_width", 32'(get_err(0)), 32'd0);
        end_frame(0);
        chk("timeout_err_count", 32'(erra - e0), 32'd1);

        // Deselect and tx_valid together in WAIT_TX: abort wins
        e0 = erra;
        send_frame(0, 16'b11_0000_0001, 16'h301);
        set_ss(0, 1'b1); set_tx(0, 1'b1, 16'hFF);
        @(negedge clk);
        chk("wait_abort_err", 32'(get_err(0)), 32'd1);
        chk("wait_abort_miso", 32'(get_miso(0)), 32'd0);
        set_tx(0, 1'b0, 16'h0);
        @(negedge clk) chk("wait_abort_miso2", 32'(get_miso(0)), 32'd0);
        chk("wait_abort_count", 32'(erra - e0), 32'd1);
        // address flag survives the abort, so this is still a read-data frame
        send_frame(0, 16'b11_0000_0010, 16'h302);
        read_out(0, 16'h81, 1);
        end_frame(0);

        // Reset in the middle of SEND
        send_frame(0, 16'b10_0000_0011, 16'h203);
        end_frame(0);
        send_frame(0, 16'b11_0000_0000, 16'h300);
        set_tx(0, 1'b1, 16'hFF);
        @(negedge clk) set_tx(0, 1'b0, 16'h0);
        repeat (3) @(negedge clk);
        chk("miso_before_rst", 32'(get_miso(0)), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_miso", 32'(ifa.MISO), 32'd0);
        chk("rst_rx_data", 32'(ifa.rx_data), 32'd0);
        chk("rst_flags", {30'd0, ifa.rx_valid, ifa.frame_err}, 32'd0);
        set_ss(0, 1'b1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        send_frame(0, 16'b11_1010_1010, 16'h3AA);   // address flag cleared by reset
        hold_quiet(0, 20);
        end_frame(0);

        // dut_b: LSB-first, 12-bit data
        send_frame(1, {2'b10, 12'h123}, 16'h2123);
        hold_quiet(1, 20);
        end_frame(1);
        send_frame(1, {2'b11, 12'h0F0}, 16'h30F0);
        read_out(1, 16'hA5C, 2);
        chk("rx_data_stable_b", 32'(get_rx(1)), 32'h30F0);
        end_frame(1);

        repeat (2) @(negedge clk);
        chk("rx_queue_a_drained", 32'(qa.size()), 32'd0);
        chk("rx_queue_b_drained", 32'(qb.size()), 32'd0);
        chk("frame_err_total_a", 32'(erra), 32'd3);
        chk("frame_err_total_b", 32'(errb), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
